// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: mnemonic codes, opcode/funct fields and word packers.
// The main control decoder imports the same opcode constants.
package mips_isa_pkg;

  // Symbolic mnemonic codes presented to the encoder; any other code is illegal.
  typedef enum logic [4:0] {
    MN_ADD  = 5'd0,
    MN_SUB  = 5'd1,
    MN_AND  = 5'd2,
    MN_OR   = 5'd3,
    MN_SLT  = 5'd4,
    MN_JR   = 5'd5,
    MN_LUI  = 5'd6,
    MN_ADDI = 5'd7,
    MN_SLTI = 5'd8,
    MN_ORI  = 5'd9,
    MN_ANDI = 5'd10,
    MN_SUBI = 5'd11,
    MN_LW   = 5'd12,
    MN_SW   = 5'd13,
    MN_BEQ  = 5'd14,
    MN_BNE  = 5'd15,
    MN_BGEZ = 5'd16,
    MN_J    = 5'd17,
    MN_JAL  = 5'd18
  } mnem_e;

  // Primary opcodes, word bits [31:26].
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_SUBI   = 6'b110111;

  // R-type function codes, word bits [5:0].
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // REGIMM rt selector that picks BGEZ.
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // {op, rs, rt, rd, shamt=0, funct}
  function automatic logic [31:0] rWord(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, fn};
  endfunction

  // {op, rs, rt, imm}
  function automatic logic [31:0] iWord(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // {op, target}
  function automatic logic [31:0] jWord(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/mips_encode_comb.sv
// Combinational packer: mnemonic plus operand fields into a 32-bit MIPS word.
// Unknown mnemonics drive legal=0 and a zero word.
module mips_encode_comb
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic [31:0] word
);

  // Select layout and opcode/funct per mnemonic; unused fields are dropped.
  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (mnem)
      MN_ADD:  word = rWord(FN_ADD, rs, rt, rd);
      MN_SUB:  word = rWord(FN_SUB, rs, rt, rd);
      MN_AND:  word = rWord(FN_AND, rs, rt, rd);
      MN_OR:   word = rWord(FN_OR,  rs, rt, rd);
      MN_SLT:  word = rWord(FN_SLT, rs, rt, rd);
      MN_JR:   word = rWord(FN_JR,  rs, 5'd0, 5'd0);
      MN_LUI:  word = iWord(OP_LUI,  5'd0, rt, imm);
      MN_ADDI: word = iWord(OP_ADDI, rs, rt, imm);
      MN_SLTI: word = iWord(OP_SLTI, rs, rt, imm);
      MN_ORI:  word = iWord(OP_ORI,  rs, rt, imm);
      MN_ANDI: word = iWord(OP_ANDI, rs, rt, imm);
      MN_SUBI: word = iWord(OP_SUBI, rs, rt, imm);
      MN_LW:   word = iWord(OP_LW,   rs, rt, imm);
      MN_SW:   word = iWord(OP_SW,   rs, rt, imm);
      MN_BEQ:  word = iWord(OP_BEQ,  rs, rt, imm);
      MN_BNE:  word = iWord(OP_BNE,  rs, rt, imm);
      MN_BGEZ: word = iWord(OP_REGIMM, rs, RT_BGEZ, imm);
      MN_J:    word = jWord(OP_J,   target);
      MN_JAL:  word = jWord(OP_JAL, target);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Instruction encoder and program loader: accepts symbolic instructions,
// encodes them and writes each word to instruction memory at an
// auto-incrementing byte address.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] word_count,
  output logic              err_illegal,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic {ST_IDLE, ST_WRITE} state_e;

  state_e            state, nextState;
  logic              encLegal;
  logic [31:0]       encWord;
  logic              accept;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic [ADDR_W-1:0] wordCount;
  logic              errIllegal;
  logic [ERR_W-1:0]  errCount;

  mips_encode_comb uEncode (
    .mnem   (in_mnem),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .legal  (encLegal),
    .word   (encWord)
  );

  // A pointer reload takes priority over accepting an instruction.
  assign in_ready = (state == ST_IDLE) && !load_base;
  assign accept   = in_valid && in_ready;

  // mem_req decodes straight from the state flop, so an async reset drops it at once.
  assign mem_req     = (state == ST_WRITE);
  assign mem_addr    = memAddr;
  assign mem_wdata   = memWdata;
  assign word_count  = wordCount;
  assign err_illegal = errIllegal;
  assign err_count   = errCount;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nextState;
  end

  // Next state: legal accepts go to WRITE, which holds until memory acknowledges.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:  if (accept && encLegal) nextState = ST_WRITE;
      ST_WRITE: if (mem_ack)            nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // Write pointer, captured word, word counter and illegal-mnemonic tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memAddr    <= '0;
      memWdata   <= '0;
      wordCount  <= '0;
      errIllegal <= 1'b0;
      errCount   <= '0;
    end else if (state == ST_IDLE) begin
      if (load_base) begin
        memAddr <= {base_addr[ADDR_W-1:2], 2'b00};
      end else if (accept && encLegal) begin
        memWdata <= encWord;
      end else if (accept) begin
        errIllegal <= 1'b1;
        if (errCount != {ERR_W{1'b1}}) errCount <= errCount + ERR_W'(1);
      end
    end else if (mem_ack) begin
      memAddr   <= memAddr + ADDR_W'(4);
      wordCount <= wordCount + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed scenarios plus
// randomized instructions checked against a field-arithmetic reference model.
module tb_mips_instr_encoder;
  import mips_isa_pkg::*;

  localparam int ADDR_W = 10;
  localparam int ERR_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_base = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_mnem = '0;
  logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              mem_req;
  logic              mem_ack = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-1:0] word_count;
  logic              err_illegal;
  logic [ERR_W-1:0]  err_count;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_base(load_base), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .err_illegal(err_illegal), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // Reference state.
  int refPtr   = 0;
  int refWords = 0;
  int refErr   = 0;
  int refStick = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference encoder: field values combined with place-value arithmetic.
  function automatic bit refEncode(input logic [4:0] mn, input int unsigned rsI,
                                   input int unsigned rtI, input int unsigned rdI,
                                   input int unsigned imm, input int unsigned tgt,
                                   output int unsigned w);
    int unsigned op, fn, rs, rt, rd;
    int kind;  // 0 = register form, 1 = immediate form, 2 = jump form
    bit ok;
    op = 0; fn = 0; rs = rsI; rt = rtI; rd = rdI; kind = 1; ok = 1'b1; w = 0;
    case (mn)
      MN_ADD:  begin kind = 0; fn = 'b100000; end
      MN_SUB:  begin kind = 0; fn = 'b100010; end
      MN_AND:  begin kind = 0; fn = 'b100100; end
      MN_OR:   begin kind = 0; fn = 'b100101; end
      MN_SLT:  begin kind = 0; fn = 'b101010; end
      MN_JR:   begin kind = 0; fn = 'b001000; rt = 0; rd = 0; end
      MN_LUI:  begin op = 'b001111; rs = 0; end
      MN_ADDI: op = 'b001000;
      MN_SLTI: op = 'b001010;
      MN_ORI:  op = 'b001101;
      MN_ANDI: op = 'b001100;
      MN_SUBI: op = 'b110111;
      MN_LW:   op = 'b100011;
      MN_SW:   op = 'b101011;
      MN_BEQ:  op = 'b000100;
      MN_BNE:  op = 'b000101;
      MN_BGEZ: begin op = 'b000001; rt = 1; end
      MN_J:    begin op = 'b000010; kind = 2; end
      MN_JAL:  begin op = 'b000011; kind = 2; end
      default: ok = 1'b0;
    endcase
    if (kind == 0)      w = op * 67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + fn;
    else if (kind == 1) w = op * 67108864 + rs * 2097152 + rt * 65536 + imm;
    else                w = op * 67108864 + tgt;
    return ok;
  endfunction

  // Present one instruction at posedge+1, complete the write after ackDelay extra cycles.
  task automatic issue(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                       input int ackDelay, input bit lbInWrite, input logic [32:0] lit);
    bit ok;
    int unsigned w;
    ok = refEncode(mn, rs, rt, rd, imm, tgt, w);
    in_mnem = mn; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    #1;
    chk("rdy_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ok) begin
      chk("req_set", 32'(mem_req), 32'd1);
      chk("rdy_write", 32'(in_ready), 32'd0);
      chk("wr_addr", 32'(mem_addr), 32'(refPtr));
      chk("wr_data", mem_wdata, w);
      if (lit[32]) chk("wr_data_lit", mem_wdata, lit[31:0]);
      for (int d = 0; d < ackDelay; d++) begin
        load_base = lbInWrite;
        base_addr = 10'h100;
        @(posedge clk); #1;
        chk("hold_req", 32'(mem_req), 32'd1);
        chk("hold_addr", 32'(mem_addr), 32'(refPtr));
        chk("hold_data", mem_wdata, w);
        chk("hold_rdy", 32'(in_ready), 32'd0);
      end
      load_base = 1'b0;
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      refPtr   = (refPtr + 4) % 1024;
      refWords = (refWords + 1) % 1024;
      chk("req_drop", 32'(mem_req), 32'd0);
      chk("rdy_back", 32'(in_ready), 32'd1);
      chk("ptr_inc", 32'(mem_addr), 32'(refPtr));
      chk("word_cnt", 32'(word_count), 32'(refWords));
    end else begin
      if (refErr < 255) refErr++;
      refStick = 1;
      chk("ill_noreq", 32'(mem_req), 32'd0);
      chk("ill_sticky", 32'(err_illegal), 32'(refStick));
      chk("ill_count", 32'(err_count), 32'(refErr));
    end
  endtask

  // Reload the write pointer, optionally with a simultaneous in_valid.
  task automatic loadBase(input logic [ADDR_W-1:0] b, input bit withValid);
    base_addr = b; load_base = 1'b1; in_valid = withValid; in_mnem = MN_ADD;
    #1;
    chk("rdy_lb", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    load_base = 1'b0; in_valid = 1'b0;
    refPtr = (int'(b) / 4) * 4;
    chk("lb_ptr", 32'(mem_addr), 32'(refPtr));
    chk("lb_noreq", 32'(mem_req), 32'd0);
    chk("lb_words", 32'(word_count), 32'(refWords));
  endtask

  task automatic chkReset(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_data"}, mem_wdata, 32'd0);
    chk({tag, "_words"}, 32'(word_count), 32'd0);
    chk({tag, "_ill"}, 32'(err_illegal), 32'd0);
    chk({tag, "_errc"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    logic [4:0] mn;
    repeat (2) @(posedge clk);
    #1;
    chkReset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed encodings and handshake timing.
    issue(MN_ADDI, 5'd1, 5'd2, 5'd0, 16'h0005, 26'd0, 0, 1'b0, 33'h1_2022_0005);
    issue(MN_ADD,  5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 0, 1'b0, 33'h1_0022_1820);
    issue(MN_JR,   5'd31, 5'd9, 5'd9, 16'h1234, 26'd0, 0, 1'b0, 33'h1_03E0_0008);
    issue(MN_BGEZ, 5'd4, 5'd7, 5'd0, 16'hFFFE, 26'd0, 1, 1'b0, 33'h1_0481_FFFE);
    issue(MN_J,    5'd0, 5'd0, 5'd0, 16'h0000, 26'h10, 3, 1'b1, 33'h1_0800_0010);

    // mem_ack outside WRITE must not move the pointer or counter.
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("idle_ack_ptr", 32'(mem_addr), 32'(refPtr));
    chk("idle_ack_cnt", 32'(word_count), 32'(refWords));

    // Pointer reload near the top of memory, then wrap.
    loadBase(10'h3FE, 1'b1);
    chk("lb_3fc", 32'(mem_addr), 32'h3FC);
    issue(MN_LUI, 5'd3, 5'd8, 5'd0, 16'hBEEF, 26'd0, 0, 1'b0, 33'h1_3C08_BEEF);
    chk("wrap_zero", 32'(mem_addr), 32'd0);

    // Illegal mnemonic flood saturates the error counter.
    for (int i = 0; i < 300; i++)
      issue(5'h1F, 5'(i), 5'(i), 5'(i), 16'(i), 26'(i), 0, 1'b0, 33'h0);
    chk("err_sat", 32'(err_count), 32'hFF);

    // Reset in the middle of a write.
    in_mnem = MN_SW; in_rs = 5'd2; in_rt = 5'd3; in_imm = 16'h0010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("midw_req", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chkReset("midw");
    @(posedge clk); #1;
    rst_n = 1'b1;
    refPtr = 0; refWords = 0; refErr = 0; refStick = 0;
    @(posedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0)
        loadBase(10'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) mn = 5'($urandom_range(19, 31));
      else                           mn = 5'($urandom_range(0, 18));
      issue(mn, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom), 33'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
